// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory stage: size codes, FSM encoding,
// latched-op record and store lane/alignment rules.
package mem_stage_pkg;

  localparam int MAX_WAIT_DEFAULT = 15;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } mem_size_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic [1:0]  size;
    logic        is_unsigned;
    logic        reg_write;
    logic        is_store;
  } op_t;

  // Bytes are never misaligned; the reserved size code 2'b11 behaves as a word.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return lsb[0];
      default:   return lsb != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SIZE_BYTE: return 4'b0001 << lsb;
      SIZE_HALF: return lsb[1] ? 4'b1100 : 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SIZE_BYTE: return {4{data[7:0]}};
      SIZE_HALF: return {2{data[15:0]}};
      default:   return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load lane select and sign/zero extension (little-endian).
// Zero latency; no handshake.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lsb,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{lsb, 3'b000} +: 8];
    half_lane = lsb[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SIZE_BYTE: data = is_unsigned ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      SIZE_HALF: data = is_unsigned ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: ALU ops write back 1 cycle after accept; aligned loads/stores enter ACCESS and write back 1 cycle after dmem_ready.
// stall is high in every ACCESS cycle without dmem_ready; after MAX_WAIT such cycles the access is abandoned with bus_error.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] alu_result,
  input  logic        zero_signal,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic        reg_write,
  input  logic        branch,
  input  logic [31:0] branch_target,
  output logic        stall,
  output logic        pc_src,
  output logic [31:0] pc_target,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        addr_error,
  output logic        bus_error
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  state_e        state, state_nxt;
  op_t           op;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic          accept;
  logic          is_mem;
  logic          bad_align;
  logic          timeout;
  logic          acc_done;
  logic [31:0]   load_data;

  assign accept    = (state == ST_IDLE) && ex_valid;
  assign is_mem    = mem_read | mem_write;
  assign bad_align = misaligned(mem_size, alu_result[1:0]);
  assign timeout   = (state == ST_ACCESS) && !dmem_ready && (wait_cnt == CW'(MAX_WAIT - 1));
  assign acc_done  = (state == ST_ACCESS) && (dmem_ready || timeout);

  load_align u_load_align (
    .rdata       (dmem_rdata),
    .lsb         (op.addr[1:0]),
    .size        (op.size),
    .is_unsigned (op.is_unsigned),
    .data        (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // dmem_* are decoded from the latched op, so they stay constant for the whole access.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    stall        = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    dmem_addr    = '0;
    dmem_be      = '0;
    dmem_wdata   = '0;
    case (state)
      ST_IDLE: begin
        if (accept && is_mem && !bad_align) begin
          state_nxt    = ST_ACCESS;
          wait_cnt_nxt = '0;
        end
      end
      ST_ACCESS: begin
        stall      = !dmem_ready;
        dmem_req   = 1'b1;
        dmem_we    = op.is_store;
        dmem_addr  = {op.addr[31:2], 2'b00};
        dmem_be    = store_be(op.size, op.addr[1:0]);
        dmem_wdata = op.is_store ? store_wdata(op.size, op.store_data) : 32'b0;
        if (acc_done) begin
          state_nxt    = ST_IDLE;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op           <= '0;
      pc_src       <= 1'b0;
      pc_target    <= '0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      addr_error   <= 1'b0;
      bus_error    <= 1'b0;
    end else begin
      pc_src       <= 1'b0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      addr_error   <= 1'b0;
      bus_error    <= 1'b0;
      if (accept) begin
        op.addr        <= alu_result;
        op.store_data  <= store_data;
        op.rd          <= rd;
        op.size        <= mem_size;
        op.is_unsigned <= mem_unsigned;
        op.reg_write   <= reg_write;
        op.is_store    <= mem_write;
        pc_src         <= branch & zero_signal;
        pc_target      <= branch_target;
        if (!is_mem) begin
          wb_valid     <= 1'b1;
          wb_reg_write <= reg_write;
          wb_rd        <= rd;
          wb_data      <= alu_result;
        end else if (bad_align) begin
          wb_valid   <= 1'b1;
          wb_rd      <= rd;
          wb_data    <= '0;
          addr_error <= 1'b1;
        end
      end
      if (acc_done) begin
        wb_valid <= 1'b1;
        wb_rd    <= op.rd;
        if (dmem_ready) begin
          wb_reg_write <= op.reg_write & ~op.is_store;
          wb_data      <= op.is_store ? 32'b0 : load_data;
        end else begin
          bus_error <= 1'b1;
          wb_data   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: hand-computed vector table, randomized ops
// against an arithmetic reference model, and reset/hold corner sequences.
module tb_mem_stage;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] alu_result;
  logic        zero_signal;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        reg_write;
  logic        branch;
  logic [31:0] branch_target;
  logic        stall;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        addr_error;
  logic        bus_error;

  int n_chk  = 0;
  int n_fail = 0;

  mem_stage #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .alu_result(alu_result),
    .zero_signal(zero_signal), .store_data(store_data), .rd(rd),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .reg_write(reg_write), .branch(branch),
    .branch_target(branch_target), .stall(stall), .pc_src(pc_src),
    .pc_target(pc_target), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .addr_error(addr_error), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  // Field order: inputs (mr..hold), then expectations (e_*).
  typedef struct {
    logic        mr, mw;
    logic [1:0]  size;
    logic        uns, rw;
    logic [4:0]  rd;
    logic [31:0] addr, sdata, rdata;
    int          wait_cyc;
    logic        br, zr;
    logic [31:0] target;
    logic        hold;
    logic        e_addr_err, e_bus_err;
    logic [31:0] e_dmem_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_wb_rw;
    logic [31:0] e_wb_data;
    logic        e_pc_src;
  } vec_t;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vec %0d): got %h, expected %h at %0t", nm, id, act, exp, $time);
    end
  endtask

  // Reference model: expectations derived with plain arithmetic from the op's rules.
  function automatic vec_t model(input vec_t v);
    vec_t        r;
    logic [31:0] lane;
    bit          mem;
    r   = v;
    mem = v.mr || v.mw;
    r.e_pc_src    = v.br && v.zr;
    r.e_addr_err  = mem && ((v.size == 2'd1 && v.addr % 2 != 0) || (v.size >= 2'd2 && v.addr % 4 != 0));
    r.e_bus_err   = mem && !r.e_addr_err && (v.wait_cyc >= MAX_WAIT);
    r.e_dmem_addr = v.addr - (v.addr % 4);
    if (v.size == 2'd0) begin
      r.e_be    = 4'(1 << (v.addr % 4));
      r.e_wdata = (v.sdata & 32'hFF) * 32'h0101_0101;
    end else if (v.size == 2'd1) begin
      r.e_be    = (v.addr % 4 >= 2) ? 4'hC : 4'h3;
      r.e_wdata = (v.sdata & 32'hFFFF) * 32'h0001_0001;
    end else begin
      r.e_be    = 4'hF;
      r.e_wdata = v.sdata;
    end
    r.e_wb_rw   = 1'b0;
    r.e_wb_data = 32'h0;
    if (!mem) begin
      r.e_wb_rw   = v.rw;
      r.e_wb_data = v.addr;
    end else if (!r.e_addr_err && !r.e_bus_err && !v.mw) begin
      if (v.size == 2'd0) begin
        lane = (v.rdata >> (8 * (v.addr % 4))) & 32'hFF;
        if (!v.uns && lane >= 32'd128) lane = lane - 32'd256;
      end else if (v.size == 2'd1) begin
        lane = (v.rdata >> ((v.addr % 4 >= 2) ? 16 : 0)) & 32'hFFFF;
        if (!v.uns && lane >= 32'd32768) lane = lane - 32'd65536;
      end else begin
        lane = v.rdata;
      end
      r.e_wb_rw   = v.rw;
      r.e_wb_data = lane;
    end
    return r;
  endfunction

  task automatic drive(input vec_t v);
    alu_result    = v.addr;
    zero_signal   = v.zr;
    store_data    = v.sdata;
    rd            = v.rd;
    mem_read      = v.mr;
    mem_write     = v.mw;
    mem_size      = v.size;
    mem_unsigned  = v.uns;
    reg_write     = v.rw;
    branch        = v.br;
    branch_target = v.target;
    dmem_rdata    = v.rdata;
    dmem_ready    = 1'b0;
  endtask

  // Presents one op in an IDLE cycle and follows it to writeback; every wait is bounded by MAX_WAIT.
  task automatic run_op(input vec_t v, input int id, input bit post);
    bit done;
    bit rdy;
    drive(v);
    ex_valid = 1'b1;
    @(posedge clk); #2;
    if (!v.hold) ex_valid = 1'b0;
    chk("pc_src", id, 32'(pc_src), 32'(v.e_pc_src));
    if (v.e_pc_src) chk("pc_target", id, pc_target, v.target);
    if (!(v.mr || v.mw)) begin
      chk("alu_wb_valid", id, 32'(wb_valid), 32'd1);
      chk("alu_wb_rd", id, 32'(wb_rd), 32'(v.rd));
      chk("alu_wb_reg_write", id, 32'(wb_reg_write), 32'(v.e_wb_rw));
      chk("alu_wb_data", id, wb_data, v.e_wb_data);
      chk("alu_no_req", id, 32'(dmem_req), 32'd0);
      chk("alu_no_stall", id, 32'(stall), 32'd0);
    end else if (v.e_addr_err) begin
      chk("mis_addr_error", id, 32'(addr_error), 32'd1);
      chk("mis_wb_valid", id, 32'(wb_valid), 32'd1);
      chk("mis_wb_reg_write", id, 32'(wb_reg_write), 32'd0);
      chk("mis_no_req", id, 32'(dmem_req), 32'd0);
      chk("mis_no_stall", id, 32'(stall), 32'd0);
    end else begin
      done = 1'b0;
      for (int k = 0; k < MAX_WAIT && !done; k++) begin
        rdy = (k == v.wait_cyc);
        dmem_ready = rdy;
        #1;
        chk("acc_req", id, 32'(dmem_req), 32'd1);
        chk("acc_stall", id, 32'(stall), 32'(!rdy));
        chk("acc_addr", id, dmem_addr, v.e_dmem_addr);
        chk("acc_we", id, 32'(dmem_we), 32'(v.mw));
        chk("acc_wb_idle", id, 32'(wb_valid | bus_error), 32'd0);
        if (v.mw) begin
          chk("acc_be", id, 32'(dmem_be), 32'(v.e_be));
          chk("acc_wdata", id, dmem_wdata, v.e_wdata);
        end
        @(posedge clk); #2;
        dmem_ready = 1'b0;
        if (rdy || k == MAX_WAIT - 1) begin
          done = 1'b1;
          if (v.hold) ex_valid = 1'b0;
          chk("done_wb_valid", id, 32'(wb_valid), 32'd1);
          chk("done_bus_error", id, 32'(bus_error), 32'(v.e_bus_err));
          chk("done_wb_reg_write", id, 32'(wb_reg_write), 32'(v.e_wb_rw));
          chk("done_req_dropped", id, 32'(dmem_req), 32'd0);
          if (v.e_wb_rw) begin
            chk("done_wb_data", id, wb_data, v.e_wb_data);
            chk("done_wb_rd", id, 32'(wb_rd), 32'(v.rd));
          end
        end
      end
    end
    if (post) begin
      @(posedge clk); #2;
      chk("pulses_clear", id, 32'({wb_valid, addr_error, bus_error, pc_src}), 32'd0);
      chk("back_to_idle", id, 32'(dmem_req), 32'd0);
    end
  endtask

  vec_t tbl[17];
  vec_t v;
  vec_t alu_v;
  int   kind;
  int   seen;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    //            mr mw size  uns rw rd     addr          sdata          rdata          wt  br zr target     hd | aerr berr dmem_addr   be    wdata          wbrw wb_data        pcs
    tbl[0]  = '{0, 0, 2'd0, 0, 1, 5'd5,  32'h0000_0042, 32'h0,         32'h0,         0,  0, 0, 32'h0,     0,  0, 0, 32'h0,      4'h0, 32'h0,         1, 32'h0000_0042, 0};
    tbl[1]  = '{1, 0, 2'd0, 0, 1, 5'd7,  32'h0000_1003, 32'h0,         32'h80FF_FF7F, 3,  0, 0, 32'h0,     0,  0, 0, 32'h1000,   4'h0, 32'h0,         1, 32'hFFFF_FF80, 0};
    tbl[2]  = '{1, 0, 2'd0, 1, 1, 5'd7,  32'h0000_1003, 32'h0,         32'h80FF_FF7F, 3,  0, 0, 32'h0,     0,  0, 0, 32'h1000,   4'h0, 32'h0,         1, 32'h0000_0080, 0};
    tbl[3]  = '{0, 1, 2'd1, 0, 0, 5'd0,  32'h0000_2002, 32'h1234_ABCD, 32'h0,         0,  0, 0, 32'h0,     0,  0, 0, 32'h2000,   4'hC, 32'hABCD_ABCD, 0, 32'h0,         0};
    tbl[4]  = '{1, 0, 2'd2, 0, 1, 5'd3,  32'h0000_3001, 32'h0,         32'h0,         0,  0, 0, 32'h0,     0,  1, 0, 32'h0,      4'h0, 32'h0,         0, 32'h0,         0};
    tbl[5]  = '{1, 0, 2'd2, 0, 1, 5'd3,  32'h0000_3000, 32'h0,         32'h0,         100,0, 0, 32'h0,     0,  0, 1, 32'h3000,   4'h0, 32'h0,         0, 32'h0,         0};
    tbl[6]  = '{0, 0, 2'd0, 0, 0, 5'd0,  32'h0,         32'h0,         32'h0,         0,  1, 1, 32'h400,   0,  0, 0, 32'h0,      4'h0, 32'h0,         0, 32'h0,         1};
    tbl[7]  = '{0, 0, 2'd0, 0, 1, 5'd9,  32'h0000_0099, 32'h0,         32'h0,         0,  1, 0, 32'h500,   0,  0, 0, 32'h0,      4'h0, 32'h0,         1, 32'h0000_0099, 0};
    tbl[8]  = '{1, 0, 2'd1, 0, 1, 5'd1,  32'h0000_0010, 32'h0,         32'h1234_8001, 14, 0, 0, 32'h0,     0,  0, 0, 32'h10,     4'h0, 32'h0,         1, 32'hFFFF_8001, 0};
    tbl[9]  = '{1, 0, 2'd1, 1, 1, 5'd2,  32'h0000_0012, 32'h0,         32'h8001_7FFF, 2,  0, 0, 32'h0,     0,  0, 0, 32'h10,     4'h0, 32'h0,         1, 32'h0000_8001, 0};
    tbl[10] = '{0, 1, 2'd0, 0, 1, 5'd4,  32'h0000_5001, 32'h0000_00AA, 32'h0,         1,  0, 0, 32'h0,     0,  0, 0, 32'h5000,   4'h2, 32'hAAAA_AAAA, 0, 32'h0,         0};
    tbl[11] = '{0, 1, 2'd2, 0, 0, 5'd0,  32'h0000_6000, 32'hDEAD_BEEF, 32'h0,         1,  0, 0, 32'h0,     0,  0, 0, 32'h6000,   4'hF, 32'hDEAD_BEEF, 0, 32'h0,         0};
    tbl[12] = '{1, 1, 2'd2, 0, 1, 5'd6,  32'h0000_7004, 32'h1122_3344, 32'hFFFF_FFFF, 0,  0, 0, 32'h0,     0,  0, 0, 32'h7004,   4'hF, 32'h1122_3344, 0, 32'h0,         0};
    tbl[13] = '{1, 0, 2'd2, 0, 1, 5'd8,  32'h0000_8000, 32'h0,         32'hCAFE_F00D, 4,  0, 0, 32'h0,     1,  0, 0, 32'h8000,   4'h0, 32'h0,         1, 32'hCAFE_F00D, 0};
    tbl[14] = '{0, 1, 2'd1, 0, 0, 5'd0,  32'h0000_2003, 32'h0000_5555, 32'h0,         0,  0, 0, 32'h0,     0,  1, 0, 32'h0,      4'h0, 32'h0,         0, 32'h0,         0};
    tbl[15] = '{1, 0, 2'd0, 0, 1, 5'd10, 32'h0000_9001, 32'h0,         32'h0000_7F00, 0,  1, 1, 32'h1234,  0,  0, 0, 32'h9000,   4'h0, 32'h0,         1, 32'h0000_007F, 1};
    tbl[16] = '{1, 0, 2'd2, 0, 1, 5'd3,  32'h0000_3000, 32'h0,         32'h0,         15, 0, 0, 32'h0,     0,  0, 1, 32'h3000,   4'h0, 32'h0,         0, 32'h0,         0};
    alu_v   = '{0, 0, 2'd0, 0, 1, 5'd11, 32'h0000_005A, 32'h0,         32'h0,         0,  0, 0, 32'h0,     0,  0, 0, 32'h0,      4'h0, 32'h0,         1, 32'h0000_005A, 0};

    rst_n    = 1'b0;
    ex_valid = 1'b0;
    drive(tbl[0]);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_wb_valid", -1, 32'(wb_valid), 32'd0);
    chk("rst_wb_data", -1, wb_data, 32'd0);
    chk("rst_dmem_req", -1, 32'(dmem_req), 32'd0);
    chk("rst_dmem_addr", -1, dmem_addr, 32'd0);
    chk("rst_stall", -1, 32'(stall), 32'd0);
    chk("rst_pulses", -1, 32'({pc_src, addr_error, bus_error, wb_reg_write}), 32'd0);
    chk("rst_pc_target", -1, pc_target, 32'd0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 17; i++) run_op(tbl[i], i, 1'b1);

    // Back-to-back random ops: each is presented in the cycle right after the previous writeback.
    for (int i = 0; i < 300; i++) begin
      kind       = int'($urandom_range(0, 2));
      v          = alu_v;
      v.mr       = (kind == 1) || (kind == 2 && $urandom_range(0, 3) == 0);
      v.mw       = (kind == 2);
      v.size     = 2'($urandom_range(0, 2));
      v.uns      = 1'($urandom_range(0, 1));
      v.rw       = 1'($urandom_range(0, 1));
      v.rd       = 5'($urandom_range(0, 31));
      v.addr     = $urandom;
      v.sdata    = $urandom;
      v.rdata    = $urandom;
      v.wait_cyc = int'($urandom_range(0, MAX_WAIT + 1));
      v.br       = 1'($urandom_range(0, 1));
      v.zr       = 1'($urandom_range(0, 1));
      v.target   = $urandom;
      v.hold     = 1'b0;
      v          = model(v);
      run_op(v, 100 + i, 1'b0);
    end

    // Reset in the middle of an access, released away from a clock edge.
    drive(tbl[5]);
    ex_valid = 1'b1;
    @(posedge clk); #2;
    ex_valid = 1'b0;
    @(posedge clk); #2;
    chk("mid_req_before_rst", 500, 32'(dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req_drop", 500, 32'(dmem_req), 32'd0);
    chk("mid_rst_stall_drop", 500, 32'(stall), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    run_op(alu_v, 501, 1'b1);
    seen = 0;
    for (int c = 0; c < MAX_WAIT + 3; c++) begin
      @(posedge clk); #2;
      if (wb_valid || bus_error || addr_error || dmem_req) seen++;
    end
    chk("quiet_after_rst", 502, 32'(seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
